// File: rtl/bcd_updown_counter_if.sv
// Control and status bundle for the BCD up/down counter.
// The master side (tick source, stopwatch or timer front-end) drives the
// synchronous controls; the slave side (the counter) returns the registered
// count, the terminal-count pulse and the two combinational decodes.
// Control semantics: there is no valid/ready pair; every control input is
// sampled on each rising clock edge and acted on with priority
// clr > load > en, so a control is "accepted" on every edge it is high.
interface bcd_updown_counter_if #(
   parameter int DIGITS = 4
);
   logic                  clr;
   logic                  load;
   logic [4*DIGITS-1:0]   load_val;
   logic                  en;
   logic                  up;
   logic [4*DIGITS-1:0]   count;
   logic                  tc;
   logic                  at_limit;
   logic                  zero;

   modport master (
      output clr, load, load_val, en, up,
      input  count, tc, at_limit, zero
   );

   modport slave (
      input  clr, load, load_val, en, up,
      output count, tc, at_limit, zero
   );
endinterface

// File: rtl/bcd_updown_counter.sv
// Parametrised N-digit BCD up/down counter with enable, synchronous clear,
// clamped parallel load, wrap or saturate at the range limits and a
// registered terminal-count pulse for cascading.
module bcd_updown_counter #(
   parameter int DIGITS   = 4,
   parameter int SATURATE = 0
) (
   input  logic                  clk_10Hz,
   input  logic                  reset_n,
   bcd_updown_counter_if.slave   bus
);

   localparam int W = 4 * DIGITS;

   logic [W-1:0]      count_q;
   logic [W-1:0]      count_d;
   logic              tc_q;
   logic              tc_d;

   logic [DIGITS-1:0] dig_is9;
   logic [DIGITS-1:0] dig_is0;
   logic [DIGITS:0]   carry;
   logic [DIGITS:0]   borrow;
   logic [W-1:0]      step_val;
   logic [W-1:0]      load_clamped;
   logic              all9;
   logic              all0;
   logic              limit;

   // Per-digit compares, single-digit step and load clamp.
   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      logic [3:0] d;
      logic [3:0] d_inc;
      logic [3:0] d_dec;
      logic [3:0] lv;

      assign d          = count_q[4*i +: 4];
      assign lv         = bus.load_val[4*i +: 4];
      assign dig_is9[i] = (d == 4'd9);
      assign dig_is0[i] = (d == 4'd0);
      assign d_inc      = dig_is9[i] ? 4'd0 : d + 4'd1;
      assign d_dec      = dig_is0[i] ? 4'd9 : d - 4'd1;

      // A digit only moves when every lower digit sits at its roll-over value.
      assign step_val[4*i +: 4] = bus.up ? (carry[i]  ? d_inc : d)
                                         : (borrow[i] ? d_dec : d);

      // Non-BCD load nibbles are clamped so count can never hold one.
      assign load_clamped[4*i +: 4] = (lv > 4'd9) ? 4'd9 : lv;
   end

   // Carry/borrow chain: AND of the lower-digit compares, digit 0 always steps.
   always_comb begin
      carry[0]  = 1'b1;
      borrow[0] = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         carry[i+1]  = carry[i]  & dig_is9[i];
         borrow[i+1] = borrow[i] & dig_is0[i];
      end
   end

   assign all9  = carry[DIGITS];
   assign all0  = borrow[DIGITS];
   assign limit = bus.up ? all9 : all0;

   // Next count and terminal-count pulse, priority clr > load > en > hold.
   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      if (bus.clr) begin
         count_d = '0;
      end else if (bus.load) begin
         count_d = load_clamped;
      end else if (bus.en) begin
         if (limit) begin
            tc_d = 1'b1;
            // Stepping from all 9s / all 0s already yields the wrapped value.
            count_d = (SATURATE != 0) ? count_q : step_val;
         end else begin
            count_d = step_val;
         end
      end
   end

   // State register with asynchronous active-low reset.
   always_ff @(posedge clk_10Hz or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
         tc_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
      end
   end

   assign bus.count    = count_q;
   assign bus.tc       = tc_q;
   assign bus.at_limit = limit;
   assign bus.zero     = all0;

endmodule
